// File: rtl/uart_row_assembler_pkg.sv
// Shared constants, FSM state type and the shift-add row-base helper for the
// UART-to-VGA row packet path.
package uart2vga_pkg;

  localparam logic [7:0] STOP_BYTE             = 8'hDD;
  localparam logic [7:0] SUCCESSFULLY_RECEIVED = 8'hFF;
  localparam logic [7:0] NOT_ALL_RECEIVED      = 8'h11;
  localparam int         BYTE_SIZE_ROW         = 240;
  localparam int         BYTE_SIZE_Y           = 2;

  typedef enum logic [2:0] {
    S_YHI    = 3'd0,
    S_YLO    = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_ANSWER = 3'd4
  } asm_state_t;

  // y * row_bytes built only from shifted copies of y. row_bytes is a
  // constant, so this collapses to a few adders (240 -> y<<4 + y<<5 + y<<6 + y<<7).
  function automatic logic [31:0] row_base(input logic [15:0] y, input int unsigned row_bytes);
    logic [31:0] acc;
    acc = 32'd0;
    for (int i = 0; i < 16; i++) begin
      if (row_bytes[i]) begin
        acc = acc + ({16'd0, y} << i);
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/uart_row_assembler_if.sv
// Byte-stream input, frame-memory write port and answer-byte port of the
// row assembler, bundled so the parser and its environment share one bus.
interface uart_row_assembler_if #(
  parameter int ADDR_W = 17
);
  logic [7:0]        rx_data;
  logic              rx_done;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              row_done;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;

  // Parser side.
  modport master (
    input  rx_data, rx_done, tx_busy,
    output wr_en, wr_addr, wr_data, row_done, tx_start, tx_data
  );

  // Receiver / memory / transmitter side.
  modport slave (
    output rx_data, rx_done, tx_busy,
    input  wr_en, wr_addr, wr_data, row_done, tx_start, tx_data
  );
endinterface

// File: rtl/uart_row_assembler_byte_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and raises
// a single-cycle expired pulse in the TIMEOUT_CYCLES-th cycle after a clear.
module byte_timeout #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] NEAR  = CNT_W'(TIMEOUT_CYCLES - 2);
  localparam logic [CNT_W-1:0] TOP   = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_r;
  logic             expired_r;

  // Count enabled cycles; expired is registered one cycle ahead so it lands
  // exactly TIMEOUT_CYCLES cycles after the clear and never repeats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= '0;
      expired_r <= 1'b0;
    end else if (clear) begin
      cnt_r     <= '0;
      expired_r <= 1'b0;
    end else if (enable) begin
      expired_r <= (cnt_r == NEAR);
      if (cnt_r != TOP) begin
        cnt_r <= cnt_r + 1'b1;
      end else begin
        cnt_r <= cnt_r;
      end
    end else begin
      cnt_r     <= cnt_r;
      expired_r <= 1'b0;
    end
  end

  assign expired = expired_r;

endmodule

// File: rtl/uart_row_assembler.sv
// Row packet parser: Y (2 bytes), BYTE_SIZE_ROW pixels, stop byte. Pixels go
// to frame memory at Y*BYTE_SIZE_ROW+column; one answer byte per packet.
module uart_row_assembler #(
  parameter int         BYTE_SIZE_ROW         = uart2vga_pkg::BYTE_SIZE_ROW,
  parameter int         HEIGHT                = 480,
  parameter logic [7:0] STOP_BYTE             = uart2vga_pkg::STOP_BYTE,
  parameter logic [7:0] SUCCESSFULLY_RECEIVED = uart2vga_pkg::SUCCESSFULLY_RECEIVED,
  parameter logic [7:0] NOT_ALL_RECEIVED      = uart2vga_pkg::NOT_ALL_RECEIVED,
  parameter int         TIMEOUT_CYCLES        = 50000,
  parameter int         ADDR_W                = 17
) (
  input logic                  clk,
  input logic                  rst,
  uart_row_assembler_if.master bus
);

  import uart2vga_pkg::*;

  localparam int               COL_W    = $clog2(BYTE_SIZE_ROW);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(BYTE_SIZE_ROW - 1);

  asm_state_t        state_r, state_s;
  logic [7:0]        y_hi_r, y_hi_s;
  logic [ADDR_W-1:0] base_r, base_s;
  logic              bad_r, bad_s;
  logic [COL_W-1:0]  col_r, col_s;
  logic              wr_en_r, wr_en_s;
  logic [ADDR_W-1:0] wr_addr_r, wr_addr_s;
  logic [7:0]        wr_data_r, wr_data_s;
  logic              row_done_r, row_done_s;
  logic              tx_start_r, tx_start_s;
  logic [7:0]        tx_data_r, tx_data_s;

  logic [15:0]       y_full_s;
  logic              finish_s, finish_bad_s;
  logic              to_clear_s, to_enable_s, expired_s;

  assign y_full_s    = {y_hi_r, bus.rx_data};
  assign to_clear_s  = bus.rx_done || (state_r == S_YHI) || (state_r == S_ANSWER);
  assign to_enable_s = (state_r == S_YLO) || (state_r == S_DATA) || (state_r == S_STOP);

  byte_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (to_clear_s),
    .enable (to_enable_s),
    .expired(expired_s)
  );

  // Next-state and next-output logic. Every packet ends through the shared
  // finish path so a good stop byte or a timeout answers in the following
  // cycle when the transmitter is idle, and S_ANSWER only holds while busy.
  always_comb begin
    state_s      = state_r;
    y_hi_s       = y_hi_r;
    base_s       = base_r;
    bad_s        = bad_r;
    col_s        = col_r;
    wr_en_s      = 1'b0;
    wr_addr_s    = wr_addr_r;
    wr_data_s    = wr_data_r;
    row_done_s   = 1'b0;
    tx_start_s   = 1'b0;
    tx_data_s    = tx_data_r;
    finish_s     = 1'b0;
    finish_bad_s = 1'b1;

    case (state_r)
      S_YHI: begin
        if (bus.rx_done) begin
          y_hi_s  = bus.rx_data;
          state_s = S_YLO;
        end else begin
          state_s = S_YHI;
        end
      end

      S_YLO: begin
        if (bus.rx_done) begin
          base_s  = ADDR_W'(row_base(y_full_s, BYTE_SIZE_ROW));
          bad_s   = (y_full_s >= 16'(HEIGHT));
          col_s   = '0;
          state_s = S_DATA;
        end else if (expired_s) begin
          finish_s     = 1'b1;
          finish_bad_s = 1'b1;
        end else begin
          state_s = S_YLO;
        end
      end

      S_DATA: begin
        if (bus.rx_done) begin
          if (!bad_r) begin
            wr_en_s   = 1'b1;
            wr_addr_s = base_r + ADDR_W'(col_r);
            wr_data_s = bus.rx_data;
          end else begin
            wr_en_s = 1'b0;
          end
          if (col_r == COL_LAST) begin
            col_s   = '0;
            state_s = S_STOP;
          end else begin
            col_s = col_r + 1'b1;
          end
        end else if (expired_s) begin
          finish_s     = 1'b1;
          finish_bad_s = 1'b1;
        end else begin
          state_s = S_DATA;
        end
      end

      S_STOP: begin
        if (bus.rx_done) begin
          finish_s     = 1'b1;
          finish_bad_s = bad_r | (bus.rx_data != STOP_BYTE);
        end else if (expired_s) begin
          finish_s     = 1'b1;
          finish_bad_s = 1'b1;
        end else begin
          state_s = S_STOP;
        end
      end

      S_ANSWER: begin
        // Bytes arriving here are ignored; keep waiting for the transmitter.
        finish_s     = 1'b1;
        finish_bad_s = bad_r;
      end

      default: begin
        state_s = S_YHI;
        bad_s   = 1'b0;
      end
    endcase

    if (finish_s) begin
      bad_s = finish_bad_s;
      if (!bus.tx_busy) begin
        tx_start_s = 1'b1;
        tx_data_s  = finish_bad_s ? NOT_ALL_RECEIVED : SUCCESSFULLY_RECEIVED;
        row_done_s = !finish_bad_s;
        state_s    = S_YHI;
      end else begin
        state_s = S_ANSWER;
      end
    end else begin
      tx_start_s = 1'b0;
    end
  end

  // State and registered outputs; reset drops any packet in flight silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_YHI;
      y_hi_r     <= 8'h00;
      base_r     <= '0;
      bad_r      <= 1'b0;
      col_r      <= '0;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= '0;
      wr_data_r  <= 8'h00;
      row_done_r <= 1'b0;
      tx_start_r <= 1'b0;
      tx_data_r  <= 8'h00;
    end else begin
      state_r    <= state_s;
      y_hi_r     <= y_hi_s;
      base_r     <= base_s;
      bad_r      <= bad_s;
      col_r      <= col_s;
      wr_en_r    <= wr_en_s;
      wr_addr_r  <= wr_addr_s;
      wr_data_r  <= wr_data_s;
      row_done_r <= row_done_s;
      tx_start_r <= tx_start_s;
      tx_data_r  <= tx_data_s;
    end
  end

  assign bus.wr_en    = wr_en_r;
  assign bus.wr_addr  = wr_addr_r;
  assign bus.wr_data  = wr_data_r;
  assign bus.row_done = row_done_r;
  assign bus.tx_start = tx_start_r;
  assign bus.tx_data  = tx_data_r;

endmodule

// File: tb/tb_uart_row_assembler.sv
// Directed bench for uart_row_assembler: a table of whole packets plus
// hand-written timeout, busy-transmitter and mid-packet reset sequences.
module tb_uart_row_assembler;
  import uart2vga_pkg::*;

  localparam int TIMEOUT = 50000;

  logic sys_clk;
  logic rst;
  int   cyc;

  uart_row_assembler_if #(.ADDR_W(17)) bus ();

  uart_row_assembler #(
    .BYTE_SIZE_ROW (240),
    .HEIGHT        (480),
    .TIMEOUT_CYCLES(TIMEOUT),
    .ADDR_W        (17)
  ) dut (
    .clk(sys_clk),
    .rst(rst),
    .bus(bus.master)
  );

  typedef struct {
    logic [15:0] y;
    int          n_data;
    logic [7:0]  stop;
    logic [7:0]  seed;
    logic [7:0]  exp_ans;
    int          exp_writes;
    int          exp_rd;
  } vec_t;

  vec_t vecs[7];

  int n_vec = 0;
  int n_err = 0;

  // Monitor state
  int         exp_base;
  logic [7:0] exp_seed;
  int         col_seen;
  int         n_wr;
  int         n_rd;
  int         n_tx = 0;
  int         tx_base;
  int         tx_cyc;
  int         rd_cyc;
  logic [7:0] tx_val;
  int         last_rx_cyc;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Observe outputs mid-cycle: check every write against the expected row
  // address/data and log answer and row_done pulses.
  always @(negedge sys_clk) begin
    if (!rst && bus.wr_en === 1'b1) begin
      check("wr_addr", 32'(bus.wr_addr), 32'(exp_base + col_seen));
      check("wr_data", 32'(bus.wr_data), 32'(8'(exp_seed + 8'(col_seen))));
      col_seen++;
      n_wr++;
    end
    if (bus.tx_start === 1'b1) begin
      n_tx++;
      tx_cyc = cyc;
      tx_val = bus.tx_data;
    end
    if (bus.row_done === 1'b1) begin
      n_rd++;
      rd_cyc = cyc;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge sys_clk);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    last_rx_cyc = cyc;
    @(negedge sys_clk);
    bus.rx_done = 1'b0;
  endtask

  task automatic do_packet(input logic [15:0] y, input int n_data, input bit with_stop,
                           input logic [7:0] stop, input logic [7:0] seed);
    exp_base = int'(y) * 240;
    exp_seed = seed;
    col_seen = 0;
    n_wr     = 0;
    n_rd     = 0;
    tx_base  = n_tx;
    send_byte(y[15:8]);
    send_byte(y[7:0]);
    for (int i = 0; i < n_data; i++) send_byte(8'(seed + 8'(i)));
    if (with_stop) send_byte(stop);
  endtask

  task automatic wait_tx(input string name, input int limit);
    int k;
    k = 0;
    while (n_tx == tx_base && k < limit) begin
      @(negedge sys_clk);
      k++;
    end
    @(negedge sys_clk);
    check({name, "_arrived"}, 32'(n_tx - tx_base), 32'd1);
  endtask

  task automatic expect_answer(input string name, input logic [7:0] ans, input int writes,
                               input int rd, input int ref_cyc, input int lat);
    repeat (5) @(negedge sys_clk);
    check({name, "_single_tx"}, 32'(n_tx - tx_base), 32'd1);
    check({name, "_tx_data"},   32'(tx_val), 32'(ans));
    check({name, "_tx_hold"},   32'(bus.tx_data), 32'(ans));
    check({name, "_latency"},   32'(tx_cyc - ref_cyc), 32'(lat));
    check({name, "_writes"},    32'(n_wr), 32'(writes));
    check({name, "_row_done"},  32'(n_rd), 32'(rd));
    if (rd == 1) check({name, "_rd_cycle"}, 32'(rd_cyc), 32'(tx_cyc));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_wr_en"},    32'(bus.wr_en), 32'd0);
    check({name, "_wr_addr"},  32'(bus.wr_addr), 32'd0);
    check({name, "_wr_data"},  32'(bus.wr_data), 32'd0);
    check({name, "_row_done"}, 32'(bus.row_done), 32'd0);
    check({name, "_tx_start"}, 32'(bus.tx_start), 32'd0);
    check({name, "_tx_data"},  32'(bus.tx_data), 32'd0);
  endtask

  initial begin
    #(1_500_000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f;
    rst         = 1'b1;
    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    bus.tx_busy = 1'b0;
    exp_base    = 0;
    exp_seed    = 8'h00;
    col_seen    = 0;
    n_wr        = 0;
    n_rd        = 0;
    tx_base     = 0;
    tx_cyc      = 0;
    rd_cyc      = 0;
    tx_val      = 8'h00;
    last_rx_cyc = 0;

    repeat (3) @(negedge sys_clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    //         y         n    stop   seed   ans    wr   rd
    vecs[0] = '{16'h0005, 240, 8'hDD, 8'h00, 8'hFF, 240, 1};  // good row, data = i
    vecs[1] = '{16'h0005, 240, 8'h00, 8'h00, 8'h11, 240, 0};  // bad terminator
    vecs[2] = '{16'h01E0, 240, 8'hDD, 8'h00, 8'h11, 0,   0};  // Y = HEIGHT
    vecs[3] = '{16'h01DF, 240, 8'hDD, 8'h37, 8'hFF, 240, 1};  // last row, top address 115199
    vecs[4] = '{16'h0000, 240, 8'hDD, 8'hA5, 8'hFF, 240, 1};  // row 0
    vecs[5] = '{16'hFFFF, 240, 8'hDD, 8'h10, 8'h11, 0,   0};  // far out of range
    vecs[6] = '{16'h0100, 240, 8'hDC, 8'h5A, 8'h11, 240, 0};  // near-miss terminator

    for (int v = 0; v < 7; v++) begin
      do_packet(vecs[v].y, vecs[v].n_data, 1'b1, vecs[v].stop, vecs[v].seed);
      wait_tx($sformatf("vec%0d", v), 50);
      expect_answer($sformatf("vec%0d", v), vecs[v].exp_ans, vecs[v].exp_writes,
                    vecs[v].exp_rd, last_rx_cyc, 1);
    end

    // Truncated packet: 100 pixels then silence until the watchdog answers.
    do_packet(16'd10, 100, 1'b0, 8'h00, 8'h40);
    wait_tx("trunc", TIMEOUT + 100);
    expect_answer("trunc", 8'h11, 100, 0, last_rx_cyc, TIMEOUT + 1);
    do_packet(16'd11, 240, 1'b1, 8'hDD, 8'h01);
    wait_tx("after_trunc", 50);
    expect_answer("after_trunc", 8'hFF, 240, 1, last_rx_cyc, 1);

    // Busy transmitter across the stop byte, with a stray byte in the wait.
    bus.tx_busy = 1'b1;
    do_packet(16'd7, 240, 1'b1, 8'hDD, 8'h11);
    repeat (20) @(negedge sys_clk);
    send_byte(8'h00);
    repeat (978) @(negedge sys_clk);
    check("busy_hold", 32'(n_tx - tx_base), 32'd0);
    @(negedge sys_clk);
    bus.tx_busy = 1'b0;
    f = cyc;
    wait_tx("busy", 50);
    expect_answer("busy", 8'hFF, 240, 1, f, 1);
    do_packet(16'd8, 240, 1'b1, 8'hDD, 8'h22);
    wait_tx("after_busy", 50);
    expect_answer("after_busy", 8'hFF, 240, 1, last_rx_cyc, 1);

    // Reset in the middle of the pixel stream.
    do_packet(16'd20, 50, 1'b0, 8'h00, 8'h60);
    @(negedge sys_clk);
    rst = 1'b1;
    @(negedge sys_clk);
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    repeat (300) @(negedge sys_clk);
    check("mid_reset_no_answer", 32'(n_tx - tx_base), 32'd0);
    check("mid_reset_writes", 32'(n_wr), 32'd50);
    do_packet(16'd21, 240, 1'b1, 8'hDD, 8'h70);
    wait_tx("after_reset", 50);
    expect_answer("after_reset", 8'hFF, 240, 1, last_rx_cyc, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
